// File: rtl/v2c_cmd_pkg.sv
// rtl/v2c_cmd_pkg.sv - shared types and packing helpers for the v2c command sequencer
//
// Purpose : mailbox op encoding, sequencer FSM states, the queued command
//           record and the write-data / response packing rules.
// Ports   : none (package)
package v2c_cmd_pkg;

   // Widest address a queued command record can carry; the top truncates to ADDR_W.
   localparam int V2C_ADDR_MAX = 64;

   typedef enum logic [1:0] {
      V2C_W64_64 = 2'd0,
      V2C_R64_64 = 2'd1,
      V2C_W32_64 = 2'd2,
      V2C_R32_64 = 2'd3
   } v2c_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GAP  = 2'd1,
      ST_REQ  = 2'd2,
      ST_RSP  = 2'd3
   } v2c_state_e;

   typedef struct packed {
      v2c_op_e                 op;
      logic [V2C_ADDR_MAX-1:0] adr;
      logic [63:0]             p0;
      logic [31:0]             p1;
   } v2c_cmd_t;

   typedef struct packed {
      logic [63:0] p0;
      logic [31:0] p1;
   } v2c_rsp_t;

   function automatic logic is_write(input v2c_op_e op);
      return (op == V2C_W64_64) || (op == V2C_W32_64);
   endfunction

   // WRITE32_64 carries its upper word in p0[31:0] and its lower word in p1.
   function automatic logic [63:0] pack_wdata(input v2c_op_e op, input logic [63:0] p0,
                                              input logic [31:0] p1);
      logic [63:0] w;
      case (op)
         V2C_W64_64: w = p0;
         V2C_W32_64: w = {p0[31:0], p1};
         default:    w = 64'h0;
      endcase
      return w;
   endfunction

   // READ32_64 splits the 64-bit read across p0 (upper, zero-extended) and p1 (lower).
   function automatic v2c_rsp_t pack_rsp(input v2c_op_e op, input logic [63:0] rdata);
      v2c_rsp_t r;
      r = '0;
      case (op)
         V2C_R64_64: r.p0 = rdata;
         V2C_R32_64: begin
            r.p0 = {32'h0, rdata[63:32]};
            r.p1 = rdata[31:0];
         end
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/v2c_cmd_fifo.sv
// rtl/v2c_cmd_fifo.sv - DEPTH-entry synchronous command FIFO with registered flags
//
// Purpose : holds accepted commands until the sequencer completes them.
// Ports   : clk, reset_n (async active-low)
//           push/wdata  - write side (ignored while full)
//           pop/rdata   - read side, rdata is the current head (ignored while empty)
//           full, empty, level - registered occupancy status
module v2c_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic [LW-1:0]    level_nxt;

   always_comb begin
      do_push   = push && !full;
      do_pop    = pop && !empty;
      level_nxt = level + LW'(do_push) - LW'(do_pop);
   end

   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level_nxt;
         full  <= (level_nxt == LW'(DEPTH));
         empty <= (level_nxt == '0);
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/v2c_cmd_sequencer.sv
// rtl/v2c_cmd_sequencer.sv - serializes mailbox commands onto a single req/ack memory port
//
// Purpose : queues WRITE64_64/READ64_64/WRITE32_64/READ32_64 commands, inserts
//           ipc_delay idle cycles before each request, issues one request at a
//           time and returns a p0/p1 response.
// Ports   : clk, reset_n (async active-low)
//           cmd_*      - command input handshake and fields
//           ipc_delay  - gap inserted before each request, sampled on IDLE exit
//           mem_*      - executor request/ack port
//           rsp_*      - response handshake and fields
//           fifo_level, busy, err_spur_ack - status
module v2c_cmd_sequencer
   import v2c_cmd_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DLY_W  = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [ADDR_W-1:0]      cmd_adr,
   input  logic [63:0]            cmd_p0,
   input  logic [31:0]            cmd_p1,
   input  logic [DLY_W-1:0]       ipc_delay,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_adr,
   output logic [63:0]            mem_wdata,
   input  logic                   mem_ack,
   input  logic [63:0]            mem_rdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [1:0]             rsp_op,
   output logic [63:0]            rsp_p0,
   output logic [31:0]            rsp_p1,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic                   busy,
   output logic                   err_spur_ack
);

   localparam int LW = $clog2(DEPTH) + 1;

   v2c_cmd_t          cmd_in;
   v2c_cmd_t          head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   v2c_state_e        state_q, state_d;
   logic [DLY_W-1:0]  gap_q, gap_d;
   logic              launch;
   v2c_rsp_t          rsp_pk;
   logic              mem_req_d, mem_we_d;
   logic [ADDR_W-1:0] mem_adr_d;
   logic [63:0]       mem_wdata_d;
   logic              rsp_valid_d;
   logic [1:0]        rsp_op_d;
   logic [63:0]       rsp_p0_d;
   logic [31:0]       rsp_p1_d;
   logic [LW-1:0]     level_nxt;
   logic              busy_d;

   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && !fifo_full;

   always_comb begin
      cmd_in.op  = v2c_op_e'(cmd_op);
      cmd_in.adr = V2C_ADDR_MAX'(cmd_adr);
      cmd_in.p0  = cmd_p0;
      cmd_in.p1  = cmd_p1;
   end

   v2c_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(v2c_cmd_t))
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (cmd_in),
      .pop     (pop),
      .rdata   (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Every output is registered, so this process computes next-cycle values.
   always_comb begin
      state_d     = state_q;
      gap_d       = gap_q;
      launch      = 1'b0;
      pop         = 1'b0;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_adr_d   = mem_adr;
      mem_wdata_d = mem_wdata;
      rsp_valid_d = rsp_valid;
      rsp_op_d    = rsp_op;
      rsp_p0_d    = rsp_p0;
      rsp_p1_d    = rsp_p1;
      rsp_pk      = pack_rsp(head.op, mem_rdata);

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               if (ipc_delay == '0) begin
                  launch = 1'b1;
               end else begin
                  gap_d   = ipc_delay;
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == DLY_W'(1)) launch = 1'b1;
            else                    gap_d  = gap_q - 1'b1;
         end
         ST_REQ: begin
            if (mem_ack) begin
               pop         = 1'b1;
               mem_req_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_op_d    = head.op;
               rsp_p0_d    = rsp_pk.p0;
               rsp_p1_d    = rsp_pk.p1;
               state_d     = ST_RSP;
            end
         end
         ST_RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The head entry is stable from IDLE exit until its ack, so it can be latched here.
      if (launch) begin
         state_d     = ST_REQ;
         mem_req_d   = 1'b1;
         mem_we_d    = is_write(head.op);
         mem_adr_d   = ADDR_W'(head.adr);
         mem_wdata_d = pack_wdata(head.op, head.p0, head.p1);
      end

      level_nxt = fifo_level + LW'(push) - LW'(pop);
      busy_d    = (level_nxt != '0) || (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         gap_q        <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_adr      <= '0;
         mem_wdata    <= '0;
         rsp_valid    <= 1'b0;
         rsp_op       <= '0;
         rsp_p0       <= '0;
         rsp_p1       <= '0;
         busy         <= 1'b0;
         err_spur_ack <= 1'b0;
      end else begin
         state_q      <= state_d;
         gap_q        <= gap_d;
         mem_req      <= mem_req_d;
         mem_we       <= mem_we_d;
         mem_adr      <= mem_adr_d;
         mem_wdata    <= mem_wdata_d;
         rsp_valid    <= rsp_valid_d;
         rsp_op       <= rsp_op_d;
         rsp_p0       <= rsp_p0_d;
         rsp_p1       <= rsp_p1_d;
         busy         <= busy_d;
         err_spur_ack <= err_spur_ack || (mem_ack && (state_q != ST_REQ));
      end
   end

endmodule

// File: tb/tb_v2c_cmd_sequencer.sv
// tb/tb_v2c_cmd_sequencer.sv - self-checking bench for v2c_cmd_sequencer
module tb_v2c_cmd_sequencer;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int DLY_W  = 16;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic                   cmd_valid = 1'b0;
   logic                   cmd_ready;
   logic [1:0]             cmd_op = '0;
   logic [ADDR_W-1:0]      cmd_adr = '0;
   logic [63:0]            cmd_p0 = '0;
   logic [31:0]            cmd_p1 = '0;
   logic [DLY_W-1:0]       ipc_delay = '0;
   logic                   mem_req;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_adr;
   logic [63:0]            mem_wdata;
   logic                   mem_ack = 1'b0;
   logic [63:0]            mem_rdata = '0;
   logic                   rsp_valid;
   logic                   rsp_ready = 1'b0;
   logic [1:0]             rsp_op;
   logic [63:0]            rsp_p0;
   logic [31:0]            rsp_p1;
   logic [$clog2(DEPTH):0] fifo_level;
   logic                   busy;
   logic                   err_spur_ack;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] adr;
      logic [63:0] p0;
      logic [31:0] p1;
   } cmd_s;

   cmd_s exp_q[$];

   v2c_cmd_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DLY_W(DLY_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_adr(cmd_adr),
      .cmd_p0(cmd_p0), .cmd_p1(cmd_p1), .ipc_delay(ipc_delay),
      .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
      .rsp_p0(rsp_p0), .rsp_p1(rsp_p1),
      .fifo_level(fifo_level), .busy(busy), .err_spur_ack(err_spur_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: what the executor should see and what the mailbox should get back.
   function automatic logic m_we(input logic [1:0] op);
      return (op == 2'd0) || (op == 2'd2);
   endfunction

   function automatic logic [63:0] m_wdata(input logic [1:0] op, input logic [63:0] p0,
                                           input logic [31:0] p1);
      if (op == 2'd0) return p0;
      if (op == 2'd2) return ((p0 & 64'hFFFF_FFFF) << 32) | {32'h0, p1};
      return 64'h0;
   endfunction

   function automatic logic [63:0] m_rsp0(input logic [1:0] op, input logic [63:0] rd);
      if (op == 2'd1) return rd;
      if (op == 2'd3) return rd >> 32;
      return 64'h0;
   endfunction

   function automatic logic [31:0] m_rsp1(input logic [1:0] op, input logic [63:0] rd);
      if (op == 2'd3) return 32'(rd & 64'hFFFF_FFFF);
      return 32'h0;
   endfunction

   // Offer one command from a negedge; returns at the negedge after the accepting edge.
   task automatic push_cmd(input logic [1:0] op, input logic [31:0] adr, input logic [63:0] p0,
                           input logic [31:0] p1, output int acc);
      int n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_adr = adr; cmd_p0 = p0; cmd_p1 = p1;
      while (cmd_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      acc = cyc;
      cmd_valid = 1'b0;
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL push_timeout cmd_ready=%b expected 1", cmd_ready);
      end else begin
         exp_q.push_back('{op: op, adr: adr, p0: p0, p1: p1});
      end
   endtask

   // Wait for the next request, check it against the model, ack it after ack_wait
   // cycles, hold the response for stall cycles, then consume it.
   task automatic serve_one(input int ack_wait, input int stall, input logic [63:0] rd,
                            output int rise, output int hs);
      int   n = 0;
      cmd_s e;
      logic [63:0] e0;
      logic [31:0] e1;
      rise = -1;
      hs   = -1;
      while (mem_req !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (mem_req !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL req_timeout mem_req=%b expected 1 (queued=%0d)", mem_req, exp_q.size());
         return;
      end
      rise = cyc;
      e  = exp_q.pop_front();
      e0 = m_rsp0(e.op, rd);
      e1 = m_rsp1(e.op, rd);
      checks++;
      if ({mem_we, mem_adr, mem_wdata} !== {m_we(e.op), e.adr, m_wdata(e.op, e.p0, e.p1)}) begin
         errors++;
         $display("FAIL req_fields we=%b adr=%h wdata=%h expected we=%b adr=%h wdata=%h",
                  mem_we, mem_adr, mem_wdata, m_we(e.op), e.adr, m_wdata(e.op, e.p0, e.p1));
      end
      for (int i = 0; i < ack_wait; i++) begin
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_hold mem_req=%b rsp_valid=%b expected 1/0", mem_req, rsp_valid);
         end
      end
      mem_ack = 1'b1; mem_rdata = rd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = {$urandom, $urandom};
      for (int i = 0; i <= stall; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if ({mem_req, rsp_valid, rsp_op, rsp_p0, rsp_p1} !== {1'b0, 1'b1, e.op, e0, e1}) begin
            errors++;
            $display("FAIL rsp req=%b valid=%b op=%0d p0=%h p1=%h expected 0/1 op=%0d p0=%h p1=%h",
                     mem_req, rsp_valid, rsp_op, rsp_p0, rsp_p1, e.op, e0, e1);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      hs = cyc;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rsp_drop rsp_valid=%b expected 0", rsp_valid);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({cmd_ready, mem_req, mem_we, mem_adr, mem_wdata} !== {1'b1, 1'b0, 1'b0, 32'h0, 64'h0}) begin
         errors++;
         $display("FAIL reset_cmd_mem ready=%b req=%b we=%b adr=%h wdata=%h expected 1/0/0/0/0",
                  cmd_ready, mem_req, mem_we, mem_adr, mem_wdata);
      end
      checks++;
      if ({rsp_valid, rsp_op, rsp_p0, rsp_p1} !== {1'b0, 2'd0, 64'h0, 32'h0}) begin
         errors++;
         $display("FAIL reset_rsp valid=%b op=%0d p0=%h p1=%h expected zeros",
                  rsp_valid, rsp_op, rsp_p0, rsp_p1);
      end
      checks++;
      if ({fifo_level, busy, err_spur_ack} !== {3'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_status level=%0d busy=%b err=%b expected 0/0/0",
                  fifo_level, busy, err_spur_ack);
      end
   endtask

   task automatic test_write32();
      int acc, rise, hs;
      ipc_delay = '0;
      push_cmd(2'd2, 32'h8000_0000, 64'h0000_0000_DEAD_BEEF, 32'h1234_5678, acc);
      checks++;
      if (busy !== 1'b1 || fifo_level !== 3'd1) begin
         errors++;
         $display("FAIL accept_status busy=%b level=%0d expected 1/1", busy, fifo_level);
      end
      serve_one(1, 0, {$urandom, $urandom}, rise, hs);
      checks++;
      if (rise != acc + 1) begin
         errors++;
         $display("FAIL w32_latency rise=%0d expected %0d", rise, acc + 1);
      end
      checks++;
      if (busy !== 1'b0 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL idle_status busy=%b level=%0d expected 0/0", busy, fifo_level);
      end
   endtask

   task automatic test_reads();
      int acc, rise, hs;
      ipc_delay = '0;
      push_cmd(2'd3, 32'h8000_0010, 64'h0, 32'h0, acc);
      serve_one(0, 0, 64'hCAFE_F00D_0BAD_C0DE, rise, hs);
      checks++;
      if (rise != acc + 1) begin
         errors++;
         $display("FAIL r32_latency rise=%0d expected %0d", rise, acc + 1);
      end
      push_cmd(2'd1, 32'h8000_0018, 64'h0, 32'h0, acc);
      serve_one(0, 0, 64'hCAFE_F00D_0BAD_C0DE, rise, hs);
      checks++;
      if (rise != acc + 1) begin
         errors++;
         $display("FAIL r64_latency rise=%0d expected %0d", rise, acc + 1);
      end
   endtask

   task automatic test_ipc_delay();
      int acc1, acc2, rise1, rise2, hs1, hs2;
      ipc_delay = 16'd5;
      push_cmd(2'd0, 32'h0000_1000, {$urandom, $urandom}, $urandom, acc1);
      push_cmd(2'd2, 32'h0000_1008, {$urandom, $urandom}, $urandom, acc2);
      repeat (2) @(negedge clk);
      ipc_delay = '0;
      serve_one(0, 0, {$urandom, $urandom}, rise1, hs1);
      ipc_delay = 16'd5;
      serve_one(2, 0, {$urandom, $urandom}, rise2, hs2);
      checks++;
      if (rise1 != acc1 + 6) begin
         errors++;
         $display("FAIL gap_first rise=%0d expected %0d", rise1, acc1 + 6);
      end
      checks++;
      if (rise2 != hs1 + 6) begin
         errors++;
         $display("FAIL gap_second rise=%0d expected %0d", rise2, hs1 + 6);
      end
   endtask

   task automatic test_random();
      int acc, rise, hs, d;
      for (int k = 0; k < 16; k++) begin
         d = $urandom_range(0, 4);
         ipc_delay = DLY_W'(d);
         push_cmd(2'($urandom_range(0, 3)), $urandom, {$urandom, $urandom}, $urandom, acc);
         serve_one($urandom_range(0, 3), $urandom_range(0, 2), {$urandom, $urandom}, rise, hs);
         checks++;
         if (rise != acc + 1 + d) begin
            errors++;
            $display("FAIL rand_latency k=%0d rise=%0d expected %0d", k, rise, acc + 1 + d);
         end
      end
   endtask

   task automatic test_back_to_back();
      int acc, rise, hs, prev_hs, d;
      d = $urandom_range(0, 3);
      ipc_delay = DLY_W'(d);
      for (int k = 0; k < 3; k++)
         push_cmd(2'($urandom_range(0, 3)), $urandom, {$urandom, $urandom}, $urandom, acc);
      serve_one(0, 0, {$urandom, $urandom}, rise, prev_hs);
      for (int k = 0; k < 2; k++) begin
         serve_one($urandom_range(0, 2), 0, {$urandom, $urandom}, rise, hs);
         checks++;
         if (rise != prev_hs + 1 + d) begin
            errors++;
            $display("FAIL b2b_spacing k=%0d rise=%0d expected %0d", k, rise, prev_hs + 1 + d);
         end
         prev_hs = hs;
      end
   endtask

   task automatic test_fifo_full();
      int acc, rise, hs;
      logic [31:0] a5;
      logic [63:0] p5;
      ipc_delay = '0;
      for (int k = 0; k < DEPTH; k++)
         push_cmd(2'($urandom_range(0, 3)), 32'h2000_0000 + 32'(k * 8), {$urandom, $urandom}, $urandom, acc);
      checks++;
      if (cmd_ready !== 1'b0 || fifo_level !== 3'd4) begin
         errors++;
         $display("FAIL full_flag ready=%b level=%0d expected 0/4", cmd_ready, fifo_level);
      end
      a5 = 32'h2000_0100;
      p5 = {$urandom, $urandom};
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_adr = a5; cmd_p0 = p5; cmd_p1 = 32'h0;
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b0 || fifo_level !== 3'd4 || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL full_hold ready=%b level=%0d req=%b expected 0/4/1", cmd_ready, fifo_level, mem_req);
      end
      serve_one(0, 0, {$urandom, $urandom}, rise, hs);
      cmd_valid = 1'b0;
      exp_q.push_back('{op: 2'd0, adr: a5, p0: p5, p1: 32'h0});
      checks++;
      if (fifo_level !== 3'd4) begin
         errors++;
         $display("FAIL full_refill level=%0d expected 4", fifo_level);
      end
      for (int k = 0; k < DEPTH; k++)
         serve_one($urandom_range(0, 1), 0, {$urandom, $urandom}, rise, hs);
      checks++;
      if (exp_q.size() != 0 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL drain queued=%0d level=%0d expected 0/0", exp_q.size(), fifo_level);
      end
   endtask

   task automatic test_rsp_stall_spur();
      int acc, rise, hs;
      ipc_delay = '0;
      push_cmd(2'd1, 32'h3000_0000, 64'h0, 32'h0, acc);
      push_cmd(2'd2, 32'h3000_0008, {$urandom, $urandom}, $urandom, acc);
      serve_one(0, 10, {$urandom, $urandom}, rise, hs);
      serve_one(1, 0, {$urandom, $urandom}, rise, hs);
      checks++;
      if (err_spur_ack !== 1'b0) begin
         errors++;
         $display("FAIL spur_pre err=%b expected 0", err_spur_ack);
      end
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if ({err_spur_ack, mem_req, rsp_valid} !== 3'b100) begin
         errors++;
         $display("FAIL spur_idle err=%b req=%b rsp_valid=%b expected 1/0/0", err_spur_ack, mem_req, rsp_valid);
      end
   endtask

   task automatic test_reset_mid();
      int acc, rise, hs, n = 0;
      ipc_delay = '0;
      push_cmd(2'd0, 32'h4000_0000, {$urandom, $urandom}, $urandom, acc);
      push_cmd(2'd1, 32'h4000_0008, 64'h0, 32'h0, acc);
      while (mem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, fifo_level, rsp_valid, cmd_ready, busy, err_spur_ack} !== {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset req=%b level=%0d rsp_valid=%b ready=%b busy=%b err=%b expected 0/0/0/1/0/0",
                  mem_req, fifo_level, rsp_valid, cmd_ready, busy, err_spur_ack);
      end
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if (err_spur_ack !== 1'b1 || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL late_ack err=%b req=%b expected 1/0", err_spur_ack, mem_req);
      end
      push_cmd(2'd3, 32'h4000_0010, 64'h0, 32'h0, acc);
      serve_one(0, 0, {$urandom, $urandom}, rise, hs);
      checks++;
      if (rise != acc + 1) begin
         errors++;
         $display("FAIL post_reset rise=%0d expected %0d", rise, acc + 1);
      end
   endtask

   initial begin
      test_reset();
      test_write32();
      test_reads();
      test_ipc_delay();
      test_random();
      test_back_to_back();
      test_fifo_full();
      test_rsp_stall_spur();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cycle=%0d expected completion", cyc);
      $fatal(1);
   end

endmodule
